// File: rtl/soc_system_pio_arb_pkg.sv
// soc_system_pio_arb_pkg: shared types and constants for the PIO arbiter.
// Contents: FSM state enum, PIO slave register addresses, default bus widths.
package soc_system_pio_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE} state_e;
    localparam logic [1:0] PIO_ADDR_DATA     = 2'd0;
    localparam logic [1:0] PIO_ADDR_IRQ_MASK = 2'd2;
    localparam int PIO_DATA_W = 32;
    localparam int PIO_ADDR_W = 2;
endpackage

// File: rtl/soc_system_pio_arbiter_if.sv
// soc_system_pio_arbiter_if: requester handshake plus Avalon-MM PIO slave bus.
// Requester side: req, we, addr, wdata, lock (only with PIO_ARB_LOCK_EN), ack, rdata.
// Slave side: s_address, s_chipselect, s_write_n, s_writedata, s_readdata.
// Modport slave is the arbiter's view; modport master is the requesters'/PIO's view.
interface soc_system_pio_arbiter_if
    import soc_system_pio_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = PIO_DATA_W,
    parameter int ADDR_W  = PIO_ADDR_W
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        we;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic [NUM_REQ*DATA_W-1:0] wdata;
`ifdef PIO_ARB_LOCK_EN
    logic [NUM_REQ-1:0]        lock;
`endif
    logic [NUM_REQ-1:0]        ack;
    logic [DATA_W-1:0]         rdata;
    logic [ADDR_W-1:0]         s_address;
    logic                      s_chipselect;
    logic                      s_write_n;
    logic [DATA_W-1:0]         s_writedata;
    logic [DATA_W-1:0]         s_readdata;

    modport slave (
        input  req, we, addr, wdata,
`ifdef PIO_ARB_LOCK_EN
        input  lock,
`endif
        input  s_readdata,
        output ack, rdata, s_address, s_chipselect, s_write_n, s_writedata
    );

    modport master (
        output req, we, addr, wdata,
`ifdef PIO_ARB_LOCK_EN
        output lock,
`endif
        output s_readdata,
        input  ack, rdata, s_address, s_chipselect, s_write_n, s_writedata
    );
endinterface

// File: rtl/soc_system_pio_arbiter_rr_sel.sv
// soc_system_pio_rr_sel: combinational round-robin picker.
// Ports: eligible (request vector), last (previous grant) -> valid, idx (first
// eligible requester scanning upward from last+1 with wrap-around).
module soc_system_pio_rr_sel #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [IDX_W-1:0]   last,
    output logic               valid,
    output logic [IDX_W-1:0]   idx
);
    // Scan from the farthest offset down so the nearest eligible slot wins.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            if (eligible[(int'(last) + i) % NUM_REQ]) begin
                valid = 1'b1;
                idx   = IDX_W'((int'(last) + i) % NUM_REQ);
            end
        end
    end
endmodule

// File: rtl/soc_system_pio_arbiter.sv
// soc_system_pio_arbiter: round-robin arbiter sharing one Avalon-MM PIO slave.
// Ports: clk, reset (async, active-high), bus (soc_system_pio_arbiter_if.slave).
// Each access runs IDLE -> ISSUE -> CAPTURE; ack/rdata appear the cycle after CAPTURE.
// Optional PIO_ARB_LOCK_EN: a grant made with lock=1 keeps the bus reserved for
// that requester until it completes an access with lock=0.
module soc_system_pio_arbiter
    import soc_system_pio_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = PIO_DATA_W,
    parameter int ADDR_W  = PIO_ADDR_W
) (
    input  logic clk,
    input  logic reset,
    soc_system_pio_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    g_q, g_d, last_q, last_d, sel_idx;
    logic                we_q, we_d, sel_valid;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
    logic [NUM_REQ-1:0]  ack_q, ack_d, g_oh, eligible;
`ifdef PIO_ARB_LOCK_EN
    logic                lk_q, lk_d, locked_q, locked_d;
`endif

    assign g_oh = NUM_REQ'(1) << g_q;

    // A requester still holding req during its ack cycle is not re-granted.
`ifdef PIO_ARB_LOCK_EN
    assign eligible = bus.req & ~ack_q & (locked_q ? g_oh : {NUM_REQ{1'b1}});
`else
    assign eligible = bus.req & ~ack_q;
`endif

    soc_system_pio_rr_sel #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_sel (
        .eligible (eligible),
        .last     (last_q),
        .valid    (sel_valid),
        .idx      (sel_idx)
    );

    always_comb begin
        state_d  = state_q;
        g_d      = g_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        ack_d    = '0;
`ifdef PIO_ARB_LOCK_EN
        lk_d     = lk_q;
        locked_d = locked_q;
`endif
        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d = ISSUE;
                    g_d     = sel_idx;
                    last_d  = sel_idx;
                    we_d    = bus.we[sel_idx];
                    addr_d  = bus.addr[sel_idx*ADDR_W +: ADDR_W];
                    wdata_d = bus.wdata[sel_idx*DATA_W +: DATA_W];
`ifdef PIO_ARB_LOCK_EN
                    lk_d    = bus.lock[sel_idx];
`endif
                end
            end
            ISSUE: state_d = CAPTURE;
            CAPTURE: begin
                state_d = IDLE;
                ack_d   = g_oh;
                rdata_d = we_q ? rdata_q : bus.s_readdata;
`ifdef PIO_ARB_LOCK_EN
                locked_d = lk_q;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            g_q      <= '0;
            last_q   <= IDX_W'(NUM_REQ - 1);
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ack_q    <= '0;
`ifdef PIO_ARB_LOCK_EN
            lk_q     <= 1'b0;
            locked_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            g_q      <= g_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            ack_q    <= ack_d;
`ifdef PIO_ARB_LOCK_EN
            lk_q     <= lk_d;
            locked_q <= locked_d;
`endif
        end
    end

    assign bus.ack          = ack_q;
    assign bus.rdata        = rdata_q;
    assign bus.s_address    = addr_q;
    assign bus.s_writedata  = wdata_q;
    assign bus.s_chipselect = (state_q == ISSUE);
    assign bus.s_write_n    = !((state_q == ISSUE) && we_q);
endmodule

// File: tb/tb_soc_system_pio_arbiter.sv
// tb_soc_system_pio_arbiter: directed bench for soc_system_pio_arbiter with a PIO slave model.
module tb_soc_system_pio_arbiter;
    import soc_system_pio_arb_pkg::*;
    localparam int N = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    soc_system_pio_arbiter_if #(.NUM_REQ(N), .DATA_W(32), .ADDR_W(2)) bus ();
    soc_system_pio_arbiter #(.NUM_REQ(N), .DATA_W(32), .ADDR_W(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] pio_data, pio_mask, s_rd;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pio_data <= '0;
            pio_mask <= '0;
            s_rd     <= '0;
        end else begin
            if (bus.s_chipselect && !bus.s_write_n) begin
                if (bus.s_address == PIO_ADDR_DATA) pio_data <= bus.s_writedata;
                else if (bus.s_address == PIO_ADDR_IRQ_MASK) pio_mask <= bus.s_writedata;
            end
            s_rd <= (bus.s_address == PIO_ADDR_DATA) ? pio_data :
                    (bus.s_address == PIO_ADDR_IRQ_MASK) ? pio_mask : 32'h0;
        end
    end
    assign bus.s_readdata = s_rd;

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int          r;
        logic        w;
        logic [1:0]  a;
        logic [31:0] wd;
        logic [1:0]  ack;
        logic [31:0] rd;
        logic [31:0] data;
        logic [31:0] mask;
    } vec_t;
    vec_t v[11];

    task automatic drive(input int r, input logic w, input logic [1:0] a, input logic [31:0] wd);
        bus.req[r]            = 1'b1;
        bus.we[r]             = w;
        bus.addr[r*2 +: 2]    = a;
        bus.wdata[r*32 +: 32] = wd;
    endtask

    initial begin
        v[0]  = '{0, 1'b1, 2'd0, 32'h1,        2'b01, 32'h0,        32'h1,        32'h0};
        v[1]  = '{0, 1'b1, 2'd2, 32'h1,        2'b01, 32'h0,        32'h1,        32'h1};
        v[2]  = '{1, 1'b0, 2'd2, 32'h0,        2'b10, 32'h1,        32'h1,        32'h1};
        v[3]  = '{1, 1'b0, 2'd0, 32'h0,        2'b10, 32'h1,        32'h1,        32'h1};
        v[4]  = '{0, 1'b1, 2'd0, 32'hA5A55A5A, 2'b01, 32'h1,        32'hA5A55A5A, 32'h1};
        v[5]  = '{1, 1'b0, 2'd0, 32'h0,        2'b10, 32'hA5A55A5A, 32'hA5A55A5A, 32'h1};
        v[6]  = '{0, 1'b0, 2'd3, 32'h0,        2'b01, 32'h0,        32'hA5A55A5A, 32'h1};
        v[7]  = '{1, 1'b1, 2'd1, 32'hDEAD,     2'b10, 32'h0,        32'hA5A55A5A, 32'h1};
        v[8]  = '{0, 1'b0, 2'd0, 32'h0,        2'b01, 32'hA5A55A5A, 32'hA5A55A5A, 32'h1};
        v[9]  = '{1, 1'b1, 2'd2, 32'h3,        2'b10, 32'hA5A55A5A, 32'hA5A55A5A, 32'h3};
        v[10] = '{0, 1'b0, 2'd2, 32'h0,        2'b01, 32'h3,        32'hA5A55A5A, 32'h3};

        bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
`ifdef PIO_ARB_LOCK_EN
        bus.lock = '0;
`endif
        #2;
        chk("rst_ack", 32'(bus.ack), 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_cs", 32'(bus.s_chipselect), 32'h0);
        chk("rst_wr_n", 32'(bus.s_write_n), 32'h1);
        chk("rst_addr", 32'(bus.s_address), 32'h0);
        chk("rst_wdata", bus.s_writedata, 32'h0);
        @(posedge clk); #1 reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            @(posedge clk); #1 drive(v[i].r, v[i].w, v[i].a, v[i].wd);
            @(negedge clk);
            @(negedge clk);
            chk("issue_cs", 32'(bus.s_chipselect), 32'h1);
            chk("issue_wr_n", 32'(bus.s_write_n), 32'(!v[i].w));
            chk("issue_addr", 32'(bus.s_address), 32'(v[i].a));
            if (v[i].w) chk("issue_wdata", bus.s_writedata, v[i].wd);
            @(negedge clk);
            chk("capture_cs", 32'(bus.s_chipselect), 32'h0);
            chk("capture_ack", 32'(bus.ack), 32'h0);
            @(negedge clk);
            chk("vec_ack", 32'(bus.ack), 32'(v[i].ack));
            chk("vec_rdata", bus.rdata, v[i].rd);
            chk("vec_data", pio_data, v[i].data);
            chk("vec_mask", pio_mask, v[i].mask);
            @(posedge clk); #1 bus.req = '0;
        end

`ifdef PIO_ARB_LOCK_EN
        @(posedge clk); #1;
        drive(1, 1'b0, 2'd2, 32'h0);
        drive(0, 1'b0, 2'd0, 32'h0);
        bus.lock = 2'b10;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            chk("lock_ack", 32'(bus.ack), (k == 3 || k == 7) ? 32'h2 : (k == 10) ? 32'h1 : 32'h0);
            if (k == 3) begin
                chk("lock_rd", bus.rdata, 32'h3);
                @(posedge clk); #1 drive(1, 1'b1, 2'd2, 32'h7); bus.lock = 2'b00;
            end
            if (k == 7) begin
                @(posedge clk); #1 bus.req[1] = 1'b0;
            end
            if (k == 10) begin
                chk("lock_rd0", bus.rdata, 32'hA5A55A5A);
                chk("lock_mask", pio_mask, 32'h7);
            end
        end
        @(posedge clk); #1 bus.req = '0;
`endif

        @(posedge clk); #1 drive(0, 1'b0, 2'd2, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rst_issue_cs_pre", 32'(bus.s_chipselect), 32'h1);
        #1 reset = 1'b1;
        #1;
        chk("rst_issue_cs", 32'(bus.s_chipselect), 32'h0);
        chk("rst_issue_wr_n", 32'(bus.s_write_n), 32'h1);
        chk("rst_issue_addr", 32'(bus.s_address), 32'h0);
        chk("rst_issue_ack", 32'(bus.ack), 32'h0);
        drive(0, 1'b0, 2'd0, 32'h0);
        drive(1, 1'b0, 2'd0, 32'h0);
        @(posedge clk);
        @(negedge clk);
        chk("rst_hold_ack", 32'(bus.ack), 32'h0);
        @(posedge clk); #1 reset = 1'b0;

        for (int k = 0; k <= 12; k++) begin
            @(negedge clk);
            chk("rr_ack", 32'(bus.ack), (k % 3 != 0 || k == 0) ? 32'h0 : ((k / 3) % 2 == 1) ? 32'h1 : 32'h2);
        end
        @(posedge clk); #1 bus.req = '0;
        repeat (3) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
